// File: rtl/cross_bar_pkg.sv
// Shared crossbar types: arbitration state encoding and the round-robin index step.
package cross_bar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1
  } arb_state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping at CHANNEL_NO.
module rr_arbiter
  import cross_bar_pkg::*;
#(
  parameter int CHANNEL_NO = 4,
  parameter int MSEL_WIDTH = $clog2(CHANNEL_NO)
) (
  input  logic [CHANNEL_NO-1:0] req,
  input  logic [MSEL_WIDTH-1:0] last_grant,
  output logic [MSEL_WIDTH-1:0] grant,
  output logic                  any_req
);

  int unsigned           idx;
  logic [MSEL_WIDTH-1:0] cand;
  logic                  found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    idx   = 32'(last_grant);
    for (int i = 0; i < CHANNEL_NO; i++) begin
      idx  = rr_next(idx, CHANNEL_NO);
      cand = MSEL_WIDTH'(idx);
      if (!found && req[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/cross_bar_arb_mux.sv
// Crossbar output stage: packet-locked round-robin merge of CHANNEL_NO AXI-Stream sources.
// CROSS_BAR_ARB_MUX_OUT_REG_EN adds a 2-entry skid slice on m_axis_* (+1 cycle, full throughput).
module cross_bar_arb_mux
  import cross_bar_pkg::*;
#(
  parameter int MSEL_WIDTH = 2,
  parameter int CHANNEL_NO = 2**MSEL_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata [CHANNEL_NO],
  input  logic [CHANNEL_NO-1:0] s_axis_tvalid,
  input  logic [CHANNEL_NO-1:0] s_axis_tlast,
  output logic [CHANNEL_NO-1:0] s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  arb_state_t            state;
  logic [MSEL_WIDTH-1:0] grant;
  logic [MSEL_WIDTH-1:0] last_grant;
  logic [MSEL_WIDTH-1:0] next_grant;
  logic                  any_req;

  logic [DATA_WIDTH-1:0] mux_tdata;
  logic                  mux_tvalid;
  logic                  mux_tlast;
  logic                  mux_rdy;
  logic                  pkt_done;

  rr_arbiter #(
    .CHANNEL_NO (CHANNEL_NO),
    .MSEL_WIDTH (MSEL_WIDTH)
  ) u_rr_arbiter (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .grant      (next_grant),
    .any_req    (any_req)
  );

  always_comb begin
    mux_tdata     = '0;
    mux_tvalid    = 1'b0;
    mux_tlast     = 1'b0;
    s_axis_tready = '0;
    if (state == ACTIVE) begin
      mux_tdata            = s_axis_tdata[grant];
      mux_tvalid           = s_axis_tvalid[grant];
      mux_tlast            = s_axis_tlast[grant];
      s_axis_tready[grant] = mux_rdy;
    end
  end

  // Lock releases only when the tlast beat is accepted by whatever sits after the mux.
  assign pkt_done = mux_tvalid & mux_rdy & mux_tlast;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= MSEL_WIDTH'(CHANNEL_NO - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= next_grant;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pkt_done) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CROSS_BAR_ARB_MUX_OUT_REG_EN
  if (1) begin : g_skid
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  skid_valid;
    logic                  skid_last;

    // Skid entry catches the beat accepted while the output register is stalled.
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        out_data   <= '0;
        out_valid  <= 1'b0;
        out_last   <= 1'b0;
        skid_data  <= '0;
        skid_valid <= 1'b0;
        skid_last  <= 1'b0;
      end else begin
        if (mux_tvalid && !skid_valid && out_valid && !m_axis_tready) begin
          skid_valid <= 1'b1;
          skid_data  <= mux_tdata;
          skid_last  <= mux_tlast;
        end
        if (!out_valid || m_axis_tready) begin
          if (skid_valid) begin
            out_data   <= skid_data;
            out_last   <= skid_last;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
          end else begin
            out_data  <= mux_tdata;
            out_last  <= mux_tlast;
            out_valid <= mux_tvalid;
          end
        end
      end
    end

    assign mux_rdy       = ~skid_valid;
    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;
  end
`else
  assign mux_rdy       = m_axis_tready;
  assign m_axis_tdata  = mux_tdata;
  assign m_axis_tvalid = mux_tvalid;
  assign m_axis_tlast  = mux_tlast;
`endif

endmodule

// File: tb/tb_cross_bar_arb_mux.sv
// Directed bench for cross_bar_arb_mux: vector table plus scripted multi-cycle packet sequences.
module tb_cross_bar_arb_mux;

  localparam int N  = 4;
  localparam int DW = 32;
`ifdef CROSS_BAR_ARB_MUX_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_axis_tdata [N];
  logic [N-1:0]  s_axis_tvalid;
  logic [N-1:0]  s_axis_tlast;
  logic [N-1:0]  s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;

  always #5 aclk = ~aclk;

  cross_bar_arb_mux #(
    .MSEL_WIDTH (2),
    .CHANNEL_NO (N),
    .DATA_WIDTH (DW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  typedef struct {
    logic [N-1:0]  vld;
    logic [N-1:0]  lst;
    logic          rdy;
    logic [N-1:0]  exp_srdy;
    logic          exp_mvld;
    logic          exp_mlast;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } beat_t;

  int     passed = 0;
  int     total  = 0;
  int     cyc;
  int     src_len [N];
  int     src_npkt [N];
  int     src_pkt [N];
  int     src_beat [N];
  int     src_start [N];
  logic [N-1:0] hold_at [64];
  logic         mrdy_at [64];
  logic [N-1:0] srdy_log [64];
  beat_t  beats [$];
  vec_t   tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] exp_data(input int i, input int p, input int b);
    return {8'(i), 8'(p), 8'h00, 8'(8'hA0 + b)};
  endfunction

  task automatic check_beat(input string name, input int k, input int i, input int p,
                            input int b, input int len, input int c);
    if (k >= beats.size()) begin
      check({name, " count"}, beats.size(), k + 1);
    end else begin
      check({name, " data"}, beats[k].data, exp_data(i, p, b));
      check({name, " last"}, beats[k].last, (b == len - 1) ? 1 : 0);
      if (c >= 0) check({name, " cycle"}, beats[k].cyc, c + LAT);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_len[i]   = 1;
      src_npkt[i]  = 0;
      src_pkt[i]   = 0;
      src_beat[i]  = 0;
      src_start[i] = 0;
    end
    for (int c = 0; c < 64; c++) begin
      hold_at[c]  = '0;
      mrdy_at[c]  = 1'b1;
      srdy_log[c] = '0;
    end
    cyc = 0;
    beats.delete();
  endtask

  task automatic do_reset(input bit chk);
    areset        = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) s_axis_tdata[i] = '0;
    clear_sources();
    #1;
    if (chk) begin
      check("reset m_tvalid", m_axis_tvalid, 0);
      check("reset m_tlast", m_axis_tlast, 0);
      check("reset s_tready", s_axis_tready, 0);
    end
    @(posedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i] = (src_pkt[i] < src_npkt[i]) && (cyc >= src_start[i]) && !hold_at[cyc][i];
      s_axis_tdata[i]  = exp_data(i, src_pkt[i], src_beat[i]);
      s_axis_tlast[i]  = (src_beat[i] == src_len[i] - 1);
    end
    m_axis_tready = mrdy_at[cyc];
  endtask

  // Each iteration: drive just after the edge, sample on the falling edge, advance accepted sources.
  task automatic run(input int n);
    logic [N-1:0] hs;
    for (int k = 0; k < n; k++) begin
      drive_src();
      @(negedge aclk);
      hs = s_axis_tready & s_axis_tvalid;
      srdy_log[cyc] = s_axis_tready;
      if (m_axis_tvalid && m_axis_tready)
        beats.push_back('{data: m_axis_tdata, last: m_axis_tlast, cyc: cyc});
      @(posedge aclk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          if (src_beat[i] == src_len[i] - 1) begin
            src_beat[i] = 0;
            src_pkt[i]++;
          end else begin
            src_beat[i]++;
          end
        end
      end
    end
  endtask

  initial begin
    do_reset(1'b1);

`ifndef CROSS_BAR_ARB_MUX_OUT_REG_EN
    tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{4'b0110, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 32'hD1};
    tbl[3]  = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{4'b0101, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 32'hD2};
    tbl[5]  = '{4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 32'hD2};
    tbl[6]  = '{4'b1001, 4'b1001, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, 32'hD3};
    tbl[8]  = '{4'b0001, 4'b0001, 1'b1, 4'b1000, 1'b0, 1'b0, 32'hD3};
    tbl[9]  = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1, 32'hD3};
    tbl[10] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 32'hD0};
    tbl[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < N; i++) s_axis_tdata[i] = 32'hD0 + i;
    for (int v = 0; v < 13; v++) begin
      s_axis_tvalid = tbl[v].vld;
      s_axis_tlast  = tbl[v].lst;
      m_axis_tready = tbl[v].rdy;
      #2;
      check($sformatf("vec%0d s_tready", v), s_axis_tready, tbl[v].exp_srdy);
      check($sformatf("vec%0d m_tvalid", v), m_axis_tvalid, tbl[v].exp_mvld);
      check($sformatf("vec%0d m_tlast", v), m_axis_tlast, tbl[v].exp_mlast);
      check($sformatf("vec%0d m_tdata", v), m_axis_tdata, tbl[v].exp_data);
      @(posedge aclk);
      #1;
    end
`endif

    // Single 3-beat packet from source 2.
    do_reset(1'b0);
    src_len[2] = 3; src_npkt[2] = 1;
    run(8);
    check("single count", beats.size(), 3);
    for (int b = 0; b < 3; b++) check_beat($sformatf("single b%0d", b), b, 2, 0, b, 3, 1 + b);
    check("single srdy c0", srdy_log[0], 4'b0000);
    for (int c = 1; c <= 3; c++) check($sformatf("single srdy c%0d", c), srdy_log[c], 4'b0100);
    check("single srdy c4", srdy_log[4], 4'b0000);

    // Round robin, all sources with two 2-beat packets each.
    do_reset(1'b0);
    for (int i = 0; i < N; i++) begin src_len[i] = 2; src_npkt[i] = 2; end
    run(30);
    check("rr count", beats.size(), 16);
    for (int n = 0; n < 16; n++)
      check_beat($sformatf("rr beat%0d", n), n, (n / 2) % 4, (n / 2) / 4, n % 2, 2, 3 * (n / 2) + 1 + n % 2);

    // Backpressure on a 4-beat packet from source 1.
    do_reset(1'b0);
    src_len[1] = 4; src_npkt[1] = 1;
    for (int c = 1; c <= 8; c++) mrdy_at[c] = (c % 2 == 1);
    run(16);
    check("bp count", beats.size(), 4);
    for (int b = 0; b < 4; b++) check_beat($sformatf("bp b%0d", b), b, 1, 0, b, 4, -1);
`ifndef CROSS_BAR_ARB_MUX_OUT_REG_EN
    for (int c = 1; c <= 7; c++)
      check($sformatf("bp srdy c%0d", c), srdy_log[c], {2'b00, mrdy_at[c], 1'b0});
`endif

    // Source 3 pauses mid-packet while source 0 waits.
    do_reset(1'b0);
    src_len[3] = 4; src_npkt[3] = 1;
    src_len[0] = 2; src_npkt[0] = 1; src_start[0] = 2;
    hold_at[2] = 4'b1000; hold_at[3] = 4'b1000;
    run(14);
    check("gap count", beats.size(), 6);
    check_beat("gap s3b0", 0, 3, 0, 0, 4, 1);
    check_beat("gap s3b1", 1, 3, 0, 1, 4, 4);
    check_beat("gap s3b2", 2, 3, 0, 2, 4, 5);
    check_beat("gap s3b3", 3, 3, 0, 3, 4, 6);
    check_beat("gap s0b0", 4, 0, 0, 0, 2, 8);
    check_beat("gap s0b1", 5, 0, 0, 1, 2, 9);
    check("gap srdy c2", srdy_log[2], 4'b1000);
    check("gap srdy c3", srdy_log[3], 4'b1000);
    check("gap srdy c7", srdy_log[7], 4'b0000);
    check("gap srdy c8", srdy_log[8], 4'b0001);

    // Reset pulse during the second beat of a 5-beat packet from source 1.
    do_reset(1'b0);
    src_len[1] = 5; src_npkt[1] = 1;
    run(2);
    drive_src();
    #1;
    check("rstmid pre m_tvalid", m_axis_tvalid, 1);
    areset = 1'b1;
    #1;
    check("rstmid m_tvalid", m_axis_tvalid, 0);
    check("rstmid m_tlast", m_axis_tlast, 0);
    check("rstmid m_tdata", m_axis_tdata, 0);
    check("rstmid s_tready", s_axis_tready, 0);
    areset = 1'b0;
    clear_sources();
    src_len[0] = 2; src_npkt[0] = 1;
    src_len[1] = 2; src_npkt[1] = 1;
    run(10);
    check("rstmid count", beats.size(), 4);
    check_beat("rstmid s0b0", 0, 0, 0, 0, 2, 1);
    check_beat("rstmid s0b1", 1, 0, 0, 1, 2, 2);
    check_beat("rstmid s1b0", 2, 1, 0, 0, 2, 4);
    check_beat("rstmid s1b1", 3, 1, 0, 1, 2, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cross_bar_arb_mux.md
Name: cross_bar_arb_mux

Overview:
- Output stage of the MxN crossbar; sits directly downstream of the per-input demux buffers.
- Takes channel i of every demux buffer (CHANNEL_NO AXI-Stream slaves) and merges them onto one AXI-Stream master.
- Packet-granular round-robin arbitration: once granted, a source owns the output until its tlast beat is accepted.

Parameters:
- MSEL_WIDTH, 2, width of the grant index.
- CHANNEL_NO, 2**MSEL_WIDTH, number of input streams.
- DATA_WIDTH, 32, tdata width.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- areset  input  1  reset; asynchronous, active-high.
- s_axis_tdata  input  [DATA_WIDTH-1:0] x CHANNEL_NO (unpacked)  per-source data.
- s_axis_tvalid  input  1 x CHANNEL_NO  per-source valid.
- s_axis_tlast  input  1 x CHANNEL_NO  per-source end of packet.
- s_axis_tready  output  1 x CHANNEL_NO  per-source ready.
- m_axis_tdata  output  DATA_WIDTH  merged data.
- m_axis_tvalid  output  1  merged valid.
- m_axis_tlast  output  1  merged end of packet.
- m_axis_tready  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, grant=0, last_grant=CHANNEL_NO-1 (source 0 has first priority).
  - m_axis_tvalid=0, m_axis_tlast=0, all s_axis_tready=0.
- IDLE:
  - All s_axis_tready=0; m_axis_tvalid=0.
  - If any s_axis_tvalid: grant <= first requesting index scanning last_grant+1, last_grant+2, ... modulo CHANNEL_NO. Wraps CHANNEL_NO-1 -> 0.
  - state <= ACTIVE.
  - One arbitration bubble cycle per packet.
- ACTIVE (combinational path, zero latency):
  - m_axis_tdata/tvalid/tlast = s_axis_*[grant].
  - s_axis_tready[grant] = m_axis_tready; all other readys are 0.
  - On m_axis_tvalid && m_axis_tready && m_axis_tlast: last_grant <= grant, state <= IDLE.
- Lock rules:
  - A granted source dropping tvalid mid-packet keeps the lock; output tvalid follows it low.
  - Requests from other sources are ignored until the tlast handshake.
  - Single-beat packet (tlast on first beat) returns to IDLE after that handshake.
- Simultaneous events: new requests arriving in the same cycle as the tlast handshake are evaluated in the following IDLE cycle against the updated last_grant.
- Reset mid-packet: grant is abandoned immediately and the partial packet is truncated downstream. No recovery is attempted.
- Fairness: with all sources continuously requesting, grants rotate 0,1,...,CHANNEL_NO-1,0.
- Illegal state encoding: returns to IDLE.

Optional Feature:
- Macro: CROSS_BAR_ARB_MUX_OUT_REG_EN.
- Defined:
  - Inserts a 2-entry skid register slice between the mux and m_axis_*.
  - Adds +1 cycle latency; full throughput is kept.
  - m_axis_* come from flops and reset to 0; the slice's s-side ready gates the mux.
  - End of packet is detected on the slice input handshake.
- Undefined: pure combinational ACTIVE path as described above.

Decomposition:
- Shared package cross_bar_pkg:
  - arb_state_t enum {IDLE, ACTIVE}, reused by the demux stage.
  - Helper function for next round-robin index.
- Sub-module rr_arbiter: parameterised CHANNEL_NO.
  - Inputs: req vector, last_grant.
  - Output: grant index plus any_req, combinational.
- The optional skid slice is a local generate block, not a separate module.

Test Plan:
- Single packet: source 2 sends 3 beats (tdata 0xA0, 0xA1, 0xA2; tlast on 0xA2) with m_axis_tready=1.
  - Output beats appear cycles 1-3 after tvalid rises.
  - s_axis_tready[2] high only in ACTIVE.
- Round robin: all 4 sources request 2-beat packets continuously.
  - Grant order 0,1,2,3,0 with one idle cycle between packets.
- Backpressure: m_axis_tready toggles 1,0,1,0 during a 4-beat packet from source 1.
  - No beat lost or duplicated.
  - s_axis_tready[1] mirrors m_axis_tready; others stay 0.
- Gap/lock: granted source 3 drops tvalid for 2 cycles mid-packet while source 0 requests.
  - Grant stays 3 until tlast; source 0 is served next.
- Reset mid-packet: areset pulses during beat 2 of a 5-beat packet.
  - Outputs go to 0 asynchronously.
  - After release, source 0 has priority.
- Out-reg macro defined: repeat the round-robin test.
  - Identical beat sequence, each beat delayed +1 cycle, no bubble added under continuous ready.
